seed_stim_gen: RTL and testbench

SEED_STIM_GEN -- requirements
Module: seed_stim_gen

---
 rtl/seed_stim_gen.sv | 112 +++++++++++
 tb/tb_seed_stim_gen.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_stim_gen.sv
// ============================================================================
// Module   : seed_stim_gen
// Brief    : Seeded Galois-LFSR burst stimulus source with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seed_stim_gen #(
    parameter logic [31:0] POLY      = 32'h80200003,
    parameter int unsigned MAX_BURST = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        seed_load,
    input  logic        start,
    input  logic [3:0]  burst_len,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        zyu,
    output logic [2:0]  viirnxmvcj,
    output logic [17:0] hwej_flat,
    output logic [3:0]  beats_left,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] C_LFSR_RESET = 32'h00000001;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_nxt;
    logic [31:0] w_lfsr_step;
    logic [31:0] w_seed_safe;
    logic [3:0]  r_beats;
    logic [3:0]  w_beats_nxt;
    logic        w_len_ok;
    logic        w_xfer;

    logic [1:0][2:4][3:3][1:3] w_hwej;

    assign w_xfer      = (r_state == ST_RUN) && out_ready;
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ POLY) : (r_lfsr >> 1);
    // An all-zero state would lock the LFSR, so a zero seed maps to 1.
    assign w_seed_safe = (seed == 32'd0) ? C_LFSR_RESET : seed;
    assign w_len_ok    = (burst_len != 4'd0) && (32'(burst_len) <= MAX_BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_lfsr  <= C_LFSR_RESET;
            r_beats <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_beats <= w_beats_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_beats_nxt = r_beats;
        case (r_state)
            ST_IDLE: begin
                // Seed and start on the same edge: the first beat sees the new seed.
                if (seed_load) begin
                    w_lfsr_nxt = w_seed_safe;
                end
                if (start && w_len_ok) begin
                    w_state_nxt = ST_RUN;
                    w_beats_nxt = burst_len;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    w_lfsr_nxt  = w_lfsr_step;
                    w_beats_nxt = r_beats - 4'd1;
                    if (r_beats == 4'd1) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beats_nxt = 4'd0;
            end
        endcase
    end

    assign w_hwej     = r_lfsr[21:4];
    assign hwej_flat  = w_hwej;
    assign zyu        = r_lfsr[0];
    assign viirnxmvcj = r_lfsr[3:1];
    assign beats_left = r_beats;
    assign out_valid  = (r_state == ST_RUN);
    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_seed_stim_gen.sv
// ============================================================================
// Module   : tb_seed_stim_gen
// Brief    : Directed self-checking bench for seed_stim_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seed_stim_gen;

    logic        clk;
    logic        rst;
    logic [31:0] seed;
    logic        seed_load;
    logic        start;
    logic [3:0]  burst_len;
    logic        out_ready;
    logic        out_valid;
    logic        zyu;
    logic [2:0]  viirnxmvcj;
    logic [17:0] hwej_flat;
    logic [3:0]  beats_left;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    seed_stim_gen dut (
        .clk        (clk),
        .rst        (rst),
        .seed       (seed),
        .seed_load  (seed_load),
        .start      (start),
        .burst_len  (burst_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .zyu        (zyu),
        .viirnxmvcj (viirnxmvcj),
        .hwej_flat  (hwej_flat),
        .beats_left (beats_left),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: {out_valid, busy, done, beats_left, zyu, viirnxmvcj, hwej_flat}
    function automatic logic [28:0] obs();
        return {out_valid, busy, done, beats_left, zyu, viirnxmvcj, hwej_flat};
    endfunction

    function automatic logic [28:0] exp_out(input logic v, input logic d,
                                            input logic [3:0] bl, input logic [31:0] l);
        return {v, v, d, bl, l[0], l[3:1], l[21:4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the current burst with out_ready held, returning whether done pulsed;
    // leaves the DUT one cycle after the pulse (back in IDLE).
    task automatic run_to_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        if (seen) tick();
    endtask

    task automatic test_reset();
        logic [28:0] e;
        rst = 1'b1; seed = 32'd0; seed_load = 1'b0; start = 1'b0;
        burst_len = 4'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h1);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL reset_state: got %h want %h", obs(), e);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL post_release_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_basic_burst();
        logic [28:0] e;
        out_ready = 1'b1; burst_len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0; burst_len = 4'd0;
        e = exp_out(1'b1, 1'b0, 4'd2, 32'h00000001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL burst_beat1: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b1, 1'b0, 4'd1, 32'h80200003);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL burst_beat2: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b0, 1'b1, 4'd0, 32'hC0300002);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL burst_done: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b0, 1'b0, 4'd0, 32'hC0300002);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL burst_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_backpressure();
        logic [28:0] e;
        bit          seen;
        out_ready = 1'b0; burst_len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0; burst_len = 4'd0;
        e = exp_out(1'b1, 1'b0, 4'd3, 32'hC0300002);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL bp_enter: got %h want %h", obs(), e);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL bp_hold%0d: got %h want %h", i, obs(), e);
            end
        end
        out_ready = 1'b1;
        tick();
        e = exp_out(1'b1, 1'b0, 4'd2, 32'h60180001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL bp_resume: got %h want %h", obs(), e);
        end
        run_to_done(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL bp_done_seen: got %0d want 1", seen);
        end
        e = exp_out(1'b0, 1'b0, 4'd0, 32'hD8360002);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL bp_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_seed_zero();
        logic [28:0] e;
        seed = 32'd0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h00000001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_zero_load: got %h want %h", obs(), e);
        end
        out_ready = 1'b1; burst_len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0; burst_len = 4'd0;
        e = exp_out(1'b1, 1'b0, 4'd1, 32'h00000001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_zero_beat: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b0, 1'b1, 4'd0, 32'h80200003);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_zero_done: got %h want %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_seed_and_start();
        logic [28:0] e;
        seed = 32'h0000000E; seed_load = 1'b1; start = 1'b1; burst_len = 4'd1;
        out_ready = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0; burst_len = 4'd0; seed = 32'd0;
        e = exp_out(1'b1, 1'b0, 4'd1, 32'h0000000E);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_start_beat: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b0, 1'b1, 4'd0, 32'h00000007);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_start_done: got %h want %h", obs(), e);
        end
        tick();
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h00000007);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL seed_start_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_ignored_starts();
        logic [28:0] e;
        bit          seen;
        start = 1'b1; burst_len = 4'd0;
        tick();
        start = 1'b0;
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h00000007);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL len0_ignored: got %h want %h", obs(), e);
        end
        out_ready = 1'b0; start = 1'b1; burst_len = 4'd4;
        tick();
        e = exp_out(1'b1, 1'b0, 4'd4, 32'h00000007);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL run_enter: got %h want %h", obs(), e);
        end
        start = 1'b1; burst_len = 4'd9; seed_load = 1'b1; seed = 32'h12345678;
        tick();
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL start_in_run_ignored: got %h want %h", obs(), e);
        end
        start = 1'b0; burst_len = 4'd0; seed_load = 1'b0; seed = 32'd0;
        out_ready = 1'b1;
        run_to_done(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL run4_done_seen: got %0d want 1", seen);
        end
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h10040000);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL lfsr_retained: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [28:0] e;
        out_ready = 1'b1; start = 1'b1; burst_len = 4'd15;
        tick();
        start = 1'b0; burst_len = 4'd0;
        e = exp_out(1'b1, 1'b0, 4'd15, 32'h10040000);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL long_enter: got %h want %h", obs(), e);
        end
        repeat (7) tick();
        checks++;
        if ({out_valid, beats_left} !== {1'b1, 4'd8}) begin
            errors++; $display("FAIL long_after7: got %b_%h want 1_8", out_valid, beats_left);
        end
        #3 rst = 1'b1;
        #1;
        e = exp_out(1'b0, 1'b0, 4'd0, 32'h00000001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL reset_async: got %h want %h", obs(), e);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL reset_held%0d: got %h want %h", i, obs(), e);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL reset_release_idle: got %h want %h", obs(), e);
        end
        start = 1'b1; burst_len = 4'd1;
        tick();
        start = 1'b0; burst_len = 4'd0;
        e = exp_out(1'b1, 1'b0, 4'd1, 32'h00000001);
        checks++;
        if (obs() !== e) begin
            errors++; $display("FAIL after_reset_beat: got %h want %h", obs(), e);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_seed_zero();
        test_seed_and_start();
        test_ignored_starts();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
